// File: rtl/fp_ctrl_pkg.sv
// Shared encodings for the FP issue controller: opcodes, exception flag bit positions,
// the canonical quiet NaN, and the controller state enumeration.
package fp_ctrl_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  localparam logic [31:0] QNAN          = 32'h7FC0_0000;
  localparam logic [4:0]  FLAGS_TIMEOUT = 5'b1 << FLAG_NV;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WB    = 2'd3
  } state_e;

endpackage

// File: rtl/fp_issue_ctrl.sv
// Single-outstanding issue controller for an FP core; writeback 2 cycles after acceptance on the
// core's same-cycle path, else core latency + 2; no request buffering, WB holds until wb_ready.
module fp_issue_ctrl
  import fp_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_rd,
  output logic             fp_start,
  output logic [2:0]       fp_op,
  output logic [31:0]      fp_a,
  output logic [31:0]      fp_b,
  input  logic [31:0]      fp_result,
  input  logic [4:0]       fp_flags,
  input  logic             fp_valid,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [31:0]      wb_data,
  output logic [TAG_W-1:0] wb_rd,
  output logic [4:0]       wb_flags,
  output logic             busy,
  output logic [4:0]       fflags,
  input  logic             fflags_clr,
  output logic             timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         fp_op_q, fp_op_d;
  logic [31:0]        fp_a_q, fp_a_d;
  logic [31:0]        fp_b_q, fp_b_d;
  logic [31:0]        wb_data_q, wb_data_d;
  logic [TAG_W-1:0]   wb_rd_q, wb_rd_d;
  logic [4:0]         wb_flags_q, wb_flags_d;
  logic [4:0]         fflags_q, fflags_d;
  logic               timeout_err_q, timeout_err_d;
  logic               fp_start_q, fp_start_d;
  logic               wb_valid_q, wb_valid_d;
  logic               busy_q, busy_d;
  logic               req_ready_q, req_ready_d;
  logic               wb_hs;
  logic               timeout_hit;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fp_op_d     = fp_op_q;
    fp_a_d      = fp_a_q;
    fp_b_d      = fp_b_q;
    wb_data_d   = wb_data_q;
    wb_rd_d     = wb_rd_q;
    wb_flags_d  = wb_flags_q;
    timeout_hit = 1'b0;
    wb_hs       = wb_valid_q && wb_ready;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          fp_op_d = req_op;
          fp_a_d  = req_a;
          fp_b_d  = req_b;
          wb_rd_d = req_rd;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d = '0;
        if (fp_valid) begin
          wb_data_d  = fp_result;
          wb_flags_d = fp_flags;
          state_d    = ST_WB;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (fp_valid) begin
          wb_data_d  = fp_result;
          wb_flags_d = fp_flags;
          state_d    = ST_WB;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // Abandon the operation; any later fp_valid lands in WB/IDLE and is dropped.
          wb_data_d   = QNAN;
          wb_flags_d  = FLAGS_TIMEOUT;
          timeout_hit = 1'b1;
          state_d     = ST_WB;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WB: begin
        if (wb_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (wb_hs && fflags_clr)  fflags_d = wb_flags_q;
    else if (wb_hs)           fflags_d = fflags_q | wb_flags_q;
    else if (fflags_clr)      fflags_d = '0;
    else                      fflags_d = fflags_q;

    if (timeout_hit)          timeout_err_d = 1'b1;
    else if (fflags_clr)      timeout_err_d = 1'b0;
    else                      timeout_err_d = timeout_err_q;

    fp_start_d  = (state_d == ST_ISSUE);
    wb_valid_d  = (state_d == ST_WB);
    busy_d      = (state_d != ST_IDLE);
    req_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      fp_op_q       <= '0;
      fp_a_q        <= '0;
      fp_b_q        <= '0;
      wb_data_q     <= '0;
      wb_rd_q       <= '0;
      wb_flags_q    <= '0;
      fflags_q      <= '0;
      timeout_err_q <= 1'b0;
      fp_start_q    <= 1'b0;
      wb_valid_q    <= 1'b0;
      busy_q        <= 1'b0;
      req_ready_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      fp_op_q       <= fp_op_d;
      fp_a_q        <= fp_a_d;
      fp_b_q        <= fp_b_d;
      wb_data_q     <= wb_data_d;
      wb_rd_q       <= wb_rd_d;
      wb_flags_q    <= wb_flags_d;
      fflags_q      <= fflags_d;
      timeout_err_q <= timeout_err_d;
      fp_start_q    <= fp_start_d;
      wb_valid_q    <= wb_valid_d;
      busy_q        <= busy_d;
      req_ready_q   <= req_ready_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign fp_start    = fp_start_q;
  assign fp_op       = fp_op_q;
  assign fp_a        = fp_a_q;
  assign fp_b        = fp_b_q;
  assign wb_valid    = wb_valid_q;
  assign wb_data     = wb_data_q;
  assign wb_rd       = wb_rd_q;
  assign wb_flags    = wb_flags_q;
  assign busy        = busy_q;
  assign fflags      = fflags_q;
  assign timeout_err = timeout_err_q;

endmodule
